// File: rtl/accum_scan_pkg.sv
// Shared types for the accum_scan engine: scan modes, FSM states and memory read latency.
package accum_scan_pkg;

  typedef enum logic [1:0] {
    SUM_INCL = 2'd0,
    SUM_EXCL = 2'd1,
    MAX_S    = 2'd2
  } scan_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    ACC   = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } scan_state_e;

  localparam int READ_LAT = 1;

endpackage

// File: rtl/accum_scan_mem.sv
// DEPTH x DATA_W single-port array: registered read address, one-cycle read.
// A cycle that writes yields no read data on the following cycle.
module accum_scan_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] addr_r;
  logic              wr_r;

  // array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // read address and write-cycle marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {ADDR_W{1'b0}};
      wr_r   <= 1'b0;
    end else begin
      addr_r <= addr;
      wr_r   <= we;
    end
  end

  assign rdata = wr_r ? {DATA_W{1'bx}} : mem_r[addr_r];

endmodule

// File: rtl/accum_scan.sv
// Scan engine folding a[init_i .. end_i-1] into an accumulator (inclusive sum,
// exclusive sum or signed max) with write-back; host port can take the array.
// Optional signed-overflow detection is built when ACCUM_SCAN_OVF_EN is defined.
module accum_scan
  import accum_scan_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_enable,
  input  logic [ADDR_W-1:0] init_i,
  input  logic [ADDR_W:0]   end_i,
  input  logic [DATA_W-1:0] init_acc,
  input  logic [1:0]        mode,
  input  logic              controlArr,
  input  logic              controlArrWEnable_a,
  input  logic [ADDR_W-1:0] controlArrAddr_a,
  input  logic [DATA_W-1:0] controlArrWData_a,
  output logic [DATA_W-1:0] controlArrRData_a,
  output logic              busy,
  output logic              w_enable,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  scan_state_e              state_r, state_next_s;
  scan_mode_e               mode_r, mode_in_s;
  logic [ADDR_W:0]          i_r, end_r, end_clamp_s;
  logic signed [DATA_W-1:0] acc_r, wb_r, x_s, sum_s, acc_new_s, wb_new_s;
  logic                     busy_r, w_enable_r;
  logic [DATA_W-1:0]        result_r;
  logic                     mem_we_s;
  logic [ADDR_W-1:0]        mem_addr_s;
  logic [DATA_W-1:0]        mem_wdata_s, mem_rdata_s;

  assign end_clamp_s = (end_i > DEPTH_W) ? DEPTH_W : end_i;
  assign mode_in_s   = (mode == 2'd3) ? SUM_INCL : scan_mode_e'(mode);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next state: r_enable wins, host ownership stalls (ACC falls back to RD)
  always_comb begin
    state_next_s = state_r;
    if (r_enable) begin
      state_next_s = CHECK;
    end else if (controlArr) begin
      if (state_r == ACC) begin
        state_next_s = RD;
      end else begin
        state_next_s = state_r;
      end
    end else begin
      case (state_r)
        IDLE:    state_next_s = IDLE;
        CHECK:   state_next_s = (i_r >= end_r) ? DONE : RD;
        RD:      state_next_s = ACC;
        ACC:     state_next_s = WR;
        WR:      state_next_s = CHECK;
        DONE:    state_next_s = IDLE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // per-element fold and write-back value
  always_comb begin
    x_s       = $signed(mem_rdata_s);
    sum_s     = acc_r + x_s;
    acc_new_s = sum_s;
    wb_new_s  = sum_s;
    case (mode_r)
      SUM_INCL: wb_new_s = sum_s;
      SUM_EXCL: wb_new_s = acc_r;
      MAX_S: begin
        if (x_s > acc_r) begin
          acc_new_s = x_s;
        end else begin
          acc_new_s = acc_r;
        end
        wb_new_s = acc_new_s;
      end
      default: wb_new_s = sum_s;
    endcase
  end

  // datapath registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_r        <= {(ADDR_W+1){1'b0}};
      end_r      <= {(ADDR_W+1){1'b0}};
      acc_r      <= {DATA_W{1'b0}};
      wb_r       <= {DATA_W{1'b0}};
      mode_r     <= SUM_INCL;
      busy_r     <= 1'b0;
      w_enable_r <= 1'b0;
      result_r   <= {DATA_W{1'b0}};
    end else begin
      busy_r <= (state_next_s != IDLE);
      if (r_enable) begin
        i_r        <= {1'b0, init_i};
        end_r      <= end_clamp_s;
        acc_r      <= init_acc;
        mode_r     <= mode_in_s;
        w_enable_r <= 1'b0;
      end else if (!controlArr) begin
        case (state_r)
          ACC: begin
            acc_r <= acc_new_s;
            wb_r  <= wb_new_s;
          end
          WR:      i_r <= i_r + 1'b1;
          DONE: begin
            result_r   <= acc_r;
            w_enable_r <= 1'b1;
          end
          default: i_r <= i_r;
        endcase
      end
    end
  end

`ifdef ACCUM_SCAN_OVF_EN
  function automatic logic add_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  logic ovf_r;

  // sticky overflow on sum modes, cleared by a new run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (r_enable) begin
      ovf_r <= 1'b0;
    end else if ((state_r == ACC) && !controlArr && (mode_r != MAX_S)
                 && add_ovf(acc_r, x_s, sum_s)) begin
      ovf_r <= 1'b1;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  // host owns the array while controlArr is high; FSM write is dropped on a restart
  always_comb begin
    if (controlArr) begin
      mem_we_s    = controlArrWEnable_a;
      mem_addr_s  = controlArrAddr_a;
      mem_wdata_s = controlArrWData_a;
    end else begin
      mem_we_s    = (state_r == WR) && !r_enable;
      mem_addr_s  = i_r[ADDR_W-1:0];
      mem_wdata_s = wb_r;
    end
  end

  accum_scan_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s)
  );

  assign controlArrRData_a = mem_rdata_s;
  assign busy              = busy_r;
  assign w_enable          = w_enable_r;
  assign result            = result_r;

endmodule

// File: tb/tb_accum_scan.sv
// Self-checking bench for accum_scan: directed and randomized runs against an array-level model.
module tb_accum_scan;

  localparam int DW    = 64;
  localparam int DEPTH = 1000;
  localparam int AW    = $clog2(DEPTH);
  localparam logic signed [DW:0]   MAXW = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0]   MINW = {2'b11, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r_enable;
  logic [AW-1:0] init_i;
  logic [AW:0]   end_i;
  logic [DW-1:0] init_acc;
  logic [1:0]    mode;
  logic          controlArr;
  logic          controlArrWEnable_a;
  logic [AW-1:0] controlArrAddr_a;
  logic [DW-1:0] controlArrWData_a;
  logic [DW-1:0] controlArrRData_a;
  logic          busy;
  logic          w_enable;
  logic [DW-1:0] result;
  logic          ovf;

  int n_pass  = 0;
  int n_total = 0;
  logic signed [DW-1:0] ref_a [DEPTH];

  accum_scan #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .init_i(init_i), .end_i(end_i),
    .init_acc(init_acc), .mode(mode), .controlArr(controlArr),
    .controlArrWEnable_a(controlArrWEnable_a), .controlArrAddr_a(controlArrAddr_a),
    .controlArrWData_a(controlArrWData_a), .controlArrRData_a(controlArrRData_a),
    .busy(busy), .w_enable(w_enable), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Array-level model of one scan; updates ref_a and returns final accumulator and overflow.
  task automatic ref_scan(input int init, input int endi, input logic signed [DW-1:0] acc0,
                          input int m, output logic signed [DW-1:0] res, output logic ov);
    int e;
    logic signed [DW-1:0] acc, x;
    logic signed [DW:0]   w;
    e   = (endi > DEPTH) ? DEPTH : endi;
    acc = acc0;
    ov  = 1'b0;
    for (int k = init; k < e; k++) begin
      x = ref_a[k];
      if (m == 2) begin
        if (x > acc) acc = x;
        ref_a[k] = acc;
      end else begin
        w = acc + x;
        if (w > MAXW || w < MINW) ov = 1'b1;
        if (m == 1) ref_a[k] = acc;
        acc = w[DW-1:0];
        if (m != 1) ref_a[k] = acc;
      end
    end
`ifndef ACCUM_SCAN_OVF_EN
    ov = 1'b0;
`endif
    res = acc;
  endtask

  task automatic host_write(input int addr, input logic signed [DW-1:0] d);
    @(negedge clk);
    controlArr = 1'b1; controlArrWEnable_a = 1'b1;
    controlArrAddr_a = addr[AW-1:0]; controlArrWData_a = d;
    ref_a[addr] = d;
    @(posedge clk); #1;
    controlArr = 1'b0; controlArrWEnable_a = 1'b0;
  endtask

  task automatic host_read(input int addr, output logic [DW-1:0] d);
    @(negedge clk);
    controlArr = 1'b1; controlArrWEnable_a = 1'b0; controlArrAddr_a = addr[AW-1:0];
    @(posedge clk); #1;
    d = controlArrRData_a;
    controlArr = 1'b0;
  endtask

  task automatic pulse_start(input int init, input int endi, input logic [DW-1:0] acc0, input int m);
    r_enable = 1'b1; init_i = init[AW-1:0]; end_i = endi[AW:0]; init_acc = acc0; mode = m[1:0];
    @(posedge clk); #1;
    r_enable = 1'b0;
  endtask

  // Count cycles after the start edge until w_enable, bounded; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!w_enable && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!w_enable) cyc = -1;
  endtask

  task automatic run_scan(input int init, input int endi, input logic [DW-1:0] acc0,
                          input int m, output int cyc);
    @(negedge clk);
    pulse_start(init, endi, acc0, m);
    wait_done(cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; r_enable = 1'b0; init_i = '0; end_i = '0; init_acc = '0; mode = 2'd0;
    controlArr = 1'b0; controlArrWEnable_a = 1'b0; controlArrAddr_a = '0; controlArrWData_a = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({busy, w_enable, ovf} !== 3'b000 || result !== 64'd0)
      $display("FAIL reset_outputs: got busy=%b w_enable=%b ovf=%b result=%0d, required all 0",
               busy, w_enable, ovf, result);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || w_enable !== 1'b0)
      $display("FAIL reset_idle: got busy=%b w_enable=%b, required 0 0", busy, w_enable);
    else n_pass++;
  endtask

  // Common result/array comparison for a finished run, inline in each scenario.
  task automatic test_incl_sum();
    int cyc; logic signed [DW-1:0] er; logic eo; logic [DW-1:0] rd;
    for (int k = 0; k < 5; k++) host_write(k, k + 1);
    run_scan(0, 5, 64'd10, 0, cyc);
    ref_scan(0, 5, 64'sd10, 0, er, eo);
    n_total++;
    if (cyc !== 22) $display("FAIL incl_latency: got %0d cycles, required 22", cyc); else n_pass++;
    n_total++;
    if (result !== er || er !== 64'sd25) $display("FAIL incl_result: got %0d, required %0d", $signed(result), er); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL incl_busy_done: got %b, required 0", busy); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      host_read(k, rd);
      n_total++;
      if (rd !== ref_a[k]) $display("FAIL incl_a%0d: got %0d, required %0d", k, $signed(rd), ref_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_excl_sum();
    int cyc; logic signed [DW-1:0] er; logic eo; logic [DW-1:0] rd;
    for (int k = 0; k < 5; k++) host_write(k, k + 1);
    run_scan(0, 5, 64'd0, 1, cyc);
    ref_scan(0, 5, 64'sd0, 1, er, eo);
    n_total++;
    if (result !== er || er !== 64'sd15) $display("FAIL excl_result: got %0d, required %0d", $signed(result), er); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      host_read(k, rd);
      n_total++;
      if (rd !== ref_a[k]) $display("FAIL excl_a%0d: got %0d, required %0d", k, $signed(rd), ref_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_max();
    int cyc; logic signed [DW-1:0] er; logic eo; logic [DW-1:0] rd;
    host_write(2, -3); host_write(3, 7); host_write(4, -9);
    run_scan(2, 5, -64'sd100, 2, cyc);
    ref_scan(2, 5, -64'sd100, 2, er, eo);
    n_total++;
    if (cyc !== 14) $display("FAIL max_latency: got %0d cycles, required 14", cyc); else n_pass++;
    n_total++;
    if (result !== er || er !== 64'sd7) $display("FAIL max_result: got %0d, required %0d", $signed(result), er); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      host_read(k, rd);
      n_total++;
      if (rd !== ref_a[k]) $display("FAIL max_a%0d: got %0d, required %0d", k, $signed(rd), ref_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    int cyc; logic [DW-1:0] rd;
    for (int k = 3; k < 8; k++) host_write(k, 1000 + k);
    run_scan(7, 3, 64'd1234, 0, cyc);
    n_total++;
    if (cyc !== 2) $display("FAIL zero_latency: got %0d cycles, required 2", cyc); else n_pass++;
    n_total++;
    if (result !== 64'd1234) $display("FAIL zero_result: got %0d, required 1234", result); else n_pass++;
    for (int k = 3; k < 8; k++) begin
      host_read(k, rd);
      n_total++;
      if (rd !== ref_a[k]) $display("FAIL zero_untouched_a%0d: got %0d, required %0d", k, $signed(rd), ref_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    int cyc; logic signed [DW-1:0] er; logic eo; logic [DW-1:0] rd;
    for (int k = DEPTH - 3; k < DEPTH; k++) host_write(k, k);
    run_scan(DEPTH - 3, DEPTH + 5, 64'd1, 0, cyc);
    ref_scan(DEPTH - 3, DEPTH + 5, 64'sd1, 0, er, eo);
    n_total++;
    if (cyc !== 14) $display("FAIL clamp_latency: got %0d cycles, required 14", cyc); else n_pass++;
    n_total++;
    if (result !== er) $display("FAIL clamp_result: got %0d, required %0d", $signed(result), er); else n_pass++;
    host_read(DEPTH - 1, rd);
    n_total++;
    if (rd !== ref_a[DEPTH-1]) $display("FAIL clamp_last: got %0d, required %0d", $signed(rd), ref_a[DEPTH-1]);
    else n_pass++;
  endtask

  task automatic test_host_stall();
    int cyc; logic signed [DW-1:0] er; logic eo; logic [DW-1:0] rd;
    for (int k = 0; k < 5; k++) host_write(k, k + 1);
    @(negedge clk);
    pulse_start(0, 5, 64'd0, 0);
    repeat (6) @(posedge clk);
    #1;
    controlArr = 1'b1; controlArrWEnable_a = 1'b1; controlArrAddr_a = 1; controlArrWData_a = 64'd100;
    ref_a[1] = 64'sd100;
    @(posedge clk); #1;
    controlArrWEnable_a = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      n_total++;
      if (controlArrRData_a !== 64'd100 || busy !== 1'b1)
        $display("FAIL stall_hold%0d: got a1=%0d busy=%b, required 100 1", s, controlArrRData_a, busy);
      else n_pass++;
    end
    controlArr = 1'b0;
    wait_done(cyc);
    ref_scan(0, 5, 64'sd0, 0, er, eo);
    n_total++;
    if (cyc !== 17) $display("FAIL stall_latency: got %0d cycles, required 17", cyc); else n_pass++;
    n_total++;
    if (result !== er || er !== 64'sd113) $display("FAIL stall_result: got %0d, required %0d", $signed(result), er); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      host_read(k, rd);
      n_total++;
      if (rd !== ref_a[k]) $display("FAIL stall_a%0d: got %0d, required %0d", k, $signed(rd), ref_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_ovf_restart();
    int cyc; logic signed [DW-1:0] er; logic eo; logic [DW-1:0] rd;
    host_write(0, 1);
    run_scan(0, 1, MAXV, 0, cyc);
    ref_scan(0, 1, MAXV, 0, er, eo);
    n_total++;
    if (result !== er || er !== MINV || ovf !== eo)
      $display("FAIL ovf_single: got result=%0d ovf=%b, required %0d %b", $signed(result), ovf, er, eo);
    else n_pass++;
    for (int k = 0; k < 5; k++) host_write(k, k + 1);
    @(negedge clk);
    pulse_start(0, 5, MAXV, 0);
    repeat (6) @(posedge clk);
    #1;
    ref_scan(0, 1, MAXV, 0, er, eo);
    n_total++;
    if (ovf !== eo) $display("FAIL ovf_midrun: got %b, required %b", ovf, eo); else n_pass++;
    pulse_start(0, 5, 64'd0, 0);
    n_total++;
    if (ovf !== 1'b0 || w_enable !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_clear: got ovf=%b w_enable=%b busy=%b, required 0 0 1", ovf, w_enable, busy);
    else n_pass++;
    wait_done(cyc);
    ref_scan(0, 5, 64'sd0, 0, er, eo);
    n_total++;
    if (cyc !== 22 || result !== er || ovf !== eo)
      $display("FAIL restart_run: got cyc=%0d result=%0d ovf=%b, required 22 %0d %b", cyc, $signed(result), ovf, er, eo);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      host_read(k, rd);
      n_total++;
      if (rd !== ref_a[k]) $display("FAIL restart_a%0d: got %0d, required %0d", k, $signed(rd), ref_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int cyc, init, endi, m, n, base;
    logic signed [DW-1:0] er, acc0; logic eo; logic [DW-1:0] rd;
    base = 100;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 12; k++) host_write(base + k, {$urandom, $urandom});
      init = base + $urandom_range(0, 4);
      endi = base + $urandom_range(0, 12);
      m    = $urandom_range(0, 3);
      acc0 = {$urandom, $urandom};
      n    = (endi > init) ? endi - init : 0;
      run_scan(init, endi, acc0, m, cyc);
      ref_scan(init, endi, acc0, m, er, eo);
      n_total++;
      if (cyc !== 4 * n + 2) $display("FAIL rand%0d_latency: got %0d, required %0d", it, cyc, 4 * n + 2);
      else n_pass++;
      n_total++;
      if (result !== er || ovf !== eo)
        $display("FAIL rand%0d_result: got %0d ovf=%b, required %0d ovf=%b (mode %0d)", it, $signed(result), ovf, er, eo, m);
      else n_pass++;
      for (int k = 0; k < 12; k++) begin
        host_read(base + k, rd);
        n_total++;
        if (rd !== ref_a[base+k])
          $display("FAIL rand%0d_a%0d: got %0d, required %0d", it, base + k, $signed(rd), ref_a[base+k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    pulse_start(0, 5, 64'd5, 0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, w_enable, ovf} !== 3'b000 || result !== 64'd0)
      $display("FAIL reset_midrun: got busy=%b w_enable=%b ovf=%b result=%0d, required all 0",
               busy, w_enable, ovf, result);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || w_enable !== 1'b0)
      $display("FAIL reset_midrun_idle: got busy=%b w_enable=%b, required 0 0", busy, w_enable);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_incl_sum();
    test_excl_sum();
    test_max();
    test_zero_len();
    test_clamp();
    test_host_stall();
    test_ovf_restart();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
